// File: rtl/visual_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : visual_scan_driver_if
//  Purpose  : Bundle between the raster scan driver and a visual_* module.
//             The driver publishes the scan position, frame strobe and audio
//             peak. The visual module returns the colour for that position.
//  Signals  : oX, oY   [9:0]  current pixel coordinate (0 outside active area)
//             oFS             1 during vertical blanking
//             oPeak    [14:0] |iL| peak of the previous frame
//             iR,iG,iB [9:0]  colour for the current oX/oY
//  Modports : master - scan driver side, slave - visual module side
//  Revision : 1.0 - initial release
// ============================================================================
interface visual_scan_driver_if;
    logic [9:0]  oX;
    logic [9:0]  oY;
    logic        oFS;
    logic [14:0] oPeak;
    logic [9:0]  iR;
    logic [9:0]  iG;
    logic [9:0]  iB;

    modport master (output oX, oY, oFS, oPeak, input iR, iG, iB);
    modport slave  (input oX, oY, oFS, oPeak, output iR, iG, iB);
endinterface
`default_nettype wire

// File: rtl/visual_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : visual_scan_driver
//  Purpose  : Raster scan driver for the visual_* modules (VGA side).
//             Generates pixel coordinates and the frame strobe. Registers the
//             returned colour with DAC timing aligned to it. Tracks a
//             per-frame audio peak.
//  Ports    : iCLK       pixel clock, all state on posedge
//             iRAND_RST  asynchronous active-low reset
//             iL         signed 16-bit audio sample, iLValid its 1-clk strobe
//             vis        visual_scan_driver_if.master (oX/oY/oFS/oPeak out,
//                        iR/iG/iB in)
//             oVGA_R/G/B registered colour, 0 when blanked
//             oHS, oVS   active-low syncs
//             oBLANK_N   1 = visible pixel on the DAC outputs
//  Config   : VISUAL_SCAN_BORDER_EN - when defined, forces the outline of the
//             active area to full white (10'h3FF on R, G and B).
//  Revision : 1.0 - initial release
// ============================================================================
module visual_scan_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE     = 1
) (
    input  wire logic               iCLK,
    input  wire logic               iRAND_RST,
    input  wire logic signed [15:0] iL,
    input  wire logic               iLValid,
    visual_scan_driver_if.master    vis,
    output logic [9:0]              oVGA_R,
    output logic [9:0]              oVGA_G,
    output logic [9:0]              oVGA_B,
    output logic                    oHS,
    output logic                    oVS,
    output logic                    oBLANK_N
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits; comparisons are done at 11 bits so that bounds
    // equal to 1024 still compare correctly.
    localparam logic [10:0] c_H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_H_LAST = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] c_V_LAST = 11'(c_V_TOTAL - 1);

    // Delay bundle layout: {act, hs_raw, vs_raw, R, G, B}
    localparam int          c_BW    = 33;
    localparam logic [32:0] c_BLANK = {1'b0, 1'b1, 1'b1, 30'd0};

    if (c_H_TOTAL > 1024) begin : g_h_total_chk
        $error("visual_scan_driver: H_TOTAL exceeds 1024");
    end
    if (c_V_TOTAL > 1024) begin : g_v_total_chk
        $error("visual_scan_driver: V_TOTAL exceeds 1024");
    end
    if (PIPE < 1) begin : g_pipe_chk
        $error("visual_scan_driver: PIPE must be >= 1");
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_line_end;
    logic        w_frame_end;

    assign w_h         = {1'b0, r_hcnt};
    assign w_v         = {1'b0, r_vcnt};
    assign w_line_end  = (w_h == c_H_LAST);
    assign w_frame_end = w_line_end && (w_v == c_V_LAST);

    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_line_end) begin
            r_hcnt <= '0;
            if (w_v == c_V_LAST) begin
                r_vcnt <= '0;
            end else begin
                r_vcnt <= r_vcnt + 10'd1;
            end
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency scan position towards the visual module
    // ------------------------------------------------------------------
    logic w_act;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_act    = (w_h < c_H_ACT) && (w_v < c_V_ACT);
    assign w_hs_raw = !((w_h >= c_HS_BEG) && (w_h < c_HS_END));
    assign w_vs_raw = !((w_v >= c_VS_BEG) && (w_v < c_VS_END));

    assign vis.oX  = w_act ? r_hcnt : 10'd0;
    assign vis.oY  = w_act ? r_vcnt : 10'd0;
    assign vis.oFS = (w_v >= c_V_ACT);

    // ------------------------------------------------------------------
    // Colour source
    // ------------------------------------------------------------------
    logic [29:0] w_col;

`ifdef VISUAL_SCAN_BORDER_EN
    localparam logic [10:0] c_H_EDGE = 11'(H_ACTIVE - 1);
    localparam logic [10:0] c_V_EDGE = 11'(V_ACTIVE - 1);

    logic w_border;

    // Outside the active area the output stage blanks anyway, so the border
    // term need not be qualified with w_act here.
    assign w_border = (w_h == 11'd0) || (w_h == c_H_EDGE) ||
                      (w_v == 11'd0) || (w_v == c_V_EDGE);
    assign w_col    = w_border ? {3{10'h3FF}} : {vis.iR, vis.iG, vis.iB};
`else
    assign w_col    = {vis.iR, vis.iG, vis.iB};
`endif

    // ------------------------------------------------------------------
    // Alignment pipe: colour and timing travel together through PIPE-1
    // delay stages followed by the output register, so blanking and syncs
    // line up with the colour they belong to.
    // ------------------------------------------------------------------
    logic [c_BW-1:0] w_tap [PIPE];
    logic [c_BW-1:0] w_last;

    assign w_tap[0] = {w_act, w_hs_raw, w_vs_raw, w_col};

    for (genvar k = 1; k < PIPE; k++) begin : g_dly
        logic [c_BW-1:0] r_q;

        always_ff @(posedge iCLK or negedge iRAND_RST) begin
            if (!iRAND_RST) begin
                r_q <= c_BLANK;
            end else begin
                r_q <= w_tap[k-1];
            end
        end

        assign w_tap[k] = r_q;
    end

    assign w_last = w_tap[PIPE-1];

    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            oVGA_R   <= '0;
            oVGA_G   <= '0;
            oVGA_B   <= '0;
            oBLANK_N <= 1'b0;
            oHS      <= 1'b1;
            oVS      <= 1'b1;
        end else begin
            oBLANK_N <= w_last[32];
            oHS      <= w_last[31];
            oVS      <= w_last[30];
            if (w_last[32]) begin
                {oVGA_R, oVGA_G, oVGA_B} <= w_last[29:0];
            end else begin
                {oVGA_R, oVGA_G, oVGA_B} <= 30'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Audio peak tracker
    // ------------------------------------------------------------------
    logic [15:0] w_neg;
    logic [14:0] w_abs;
    logic [14:0] w_smp;
    logic [14:0] r_run;
    logic [14:0] r_peak;

    // -32768 has no positive 16-bit counterpart; its negation keeps bit 15
    // set, which is used to saturate to 32767.
    assign w_neg = 16'd0 - iL;
    assign w_abs = !iL[15] ? iL[14:0] : (w_neg[15] ? 15'h7FFF : w_neg[14:0]);
    assign w_smp = iLValid ? w_abs : 15'd0;

    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            r_run  <= '0;
            r_peak <= '0;
        end else if (w_frame_end) begin
            // A sample in the closing cycle still belongs to this frame.
            r_peak <= (w_smp > r_run) ? w_smp : r_run;
            r_run  <= '0;
        end else if (iLValid && (w_abs > r_run)) begin
            r_run <= w_abs;
        end
    end

    assign vis.oPeak = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_visual_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_visual_scan_driver
//  Purpose  : Self-checking bench for visual_scan_driver. Two instances with
//             a small raster (H 8/2/2/2, V 4/1/1/1) and PIPE=1 / PIPE=3 run
//             side by side. Colour is fed back as R=oX, G=oY, B=0, or all
//             zero for the border frame. Expected DAC words are queued per
//             instance when the pixel is scanned and popped when due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_visual_scan_driver;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] l = '0;
    logic               lv = 1'b0;
    logic               zero_col = 1'b0;

    always #5 clk = ~clk;

    visual_scan_driver_if if1 ();
    visual_scan_driver_if if3 ();

    assign if1.iR = zero_col ? 10'd0 : if1.oX;
    assign if1.iG = zero_col ? 10'd0 : if1.oY;
    assign if1.iB = 10'd0;
    assign if3.iR = zero_col ? 10'd0 : if3.oX;
    assign if3.iG = zero_col ? 10'd0 : if3.oY;
    assign if3.iB = 10'd0;

    logic [9:0] r1, g1, b1, r3, g3, b3;
    logic       hs1, vs1, bn1, hs3, vs3, bn3;

    visual_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE(1)
    ) u_dut1 (
        .iCLK(clk), .iRAND_RST(rst_n), .iL(l), .iLValid(lv), .vis(if1),
        .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
        .oHS(hs1), .oVS(vs1), .oBLANK_N(bn1)
    );

    visual_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE(3)
    ) u_dut3 (
        .iCLK(clk), .iRAND_RST(rst_n), .iL(l), .iLValid(lv), .vis(if3),
        .oVGA_R(r3), .oVGA_G(g3), .oVGA_B(b3),
        .oHS(hs3), .oVS(vs3), .oBLANK_N(bn3)
    );

    localparam logic [32:0] BLANK = {1'b0, 1'b1, 1'b1, 30'd0};

    int          errors = 0;
    int          checks = 0;
    int          mh, mv, mrun, mpeak;
    logic [32:0] q1[$];
    logic [32:0] q3[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected DAC word {blank_n, hs, vs, R, G, B} for raster position (h,v)
    function automatic logic [32:0] exp_pix(input int h, input int v, input bit z);
        logic       act, hs, vs;
        logic [9:0] r, g, b;
        act = (h < HA) && (v < VA);
        hs  = !((h >= HA + HF) && (h < HA + HF + HSW));
        vs  = !((v >= VA + VF) && (v < VA + VF + VSW));
        r = 10'd0; g = 10'd0; b = 10'd0;
        if (act) begin
            r = z ? 10'd0 : 10'(h);
            g = z ? 10'd0 : 10'(v);
`ifdef VISUAL_SCAN_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
                r = 10'h3FF; g = 10'h3FF; b = 10'h3FF;
            end
`endif
        end
        return {act, hs, vs, r, g, b};
    endfunction

    function automatic int abs_sat(input int s);
        int a;
        a = (s < 0) ? -s : s;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic init_model();
        mh = 0; mv = 0; mrun = 0; mpeak = 0;
        q1.delete(); q3.delete();
        q1.push_back(BLANK);
        for (int i = 0; i < 3; i++) q3.push_back(BLANK);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_peak1"}, 64'(if1.oPeak), 64'd0);
        chk({tag, "_peak3"}, 64'(if3.oPeak), 64'd0);
        chk({tag, "_dac1"}, 64'({bn1, hs1, vs1, r1, g1, b1}), 64'(BLANK));
        chk({tag, "_dac3"}, 64'({bn3, hs3, vs3, r3, g3, b3}), 64'(BLANK));
    endtask

    // One pixel clock: drive audio, check the current scan state and the
    // DAC word that is due, queue this pixel's expectation, step the model.
    task automatic cycle(input bit valid, input int sample);
        logic [32:0] e;
        bit          act;
        int          a;
        lv = valid;
        l  = 16'(sample);
        act = (mh < HA) && (mv < VA);
        chk("oX1", 64'(if1.oX), act ? 64'(mh) : 64'd0);
        chk("oY1", 64'(if1.oY), act ? 64'(mv) : 64'd0);
        chk("oFS1", 64'(if1.oFS), 64'(mv >= VA));
        chk("oX3", 64'(if3.oX), act ? 64'(mh) : 64'd0);
        chk("peak1", 64'(if1.oPeak), 64'(mpeak));
        chk("peak3", 64'(if3.oPeak), 64'(mpeak));
        if (q1.size() == 0 || q3.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
        end else begin
            e = q1.pop_front();
            chk("dac1", 64'({bn1, hs1, vs1, r1, g1, b1}), 64'(e));
            e = q3.pop_front();
            chk("dac3", 64'({bn3, hs3, vs3, r3, g3, b3}), 64'(e));
        end
        e = exp_pix(mh, mv, zero_col);
        q1.push_back(e);
        q3.push_back(e);
        a = abs_sat(sample);
        if (mh == HT - 1 && mv == VT - 1) begin
            mpeak = valid ? ((a > mrun) ? a : mrun) : mrun;
            mrun  = 0;
        end else if (valid && a > mrun) begin
            mrun = a;
        end
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        @(negedge clk);
        lv = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst0");
        @(negedge clk);
        #1 rst_n = 1'b1;
        init_model();
        chk("rel_oX", 64'(if1.oX), 64'd0);
        chk("rel_oFS", 64'(if1.oFS), 64'd0);

        // Frame 0: samples 100, -2000, 500
        for (int i = 0; i < FRAME; i++)
            cycle(i == 5 || i == 20 || i == 40,
                  (i == 5) ? 100 : (i == 20) ? -2000 : (i == 40) ? 500 : 0);
        chk("peak_f0", 64'(if1.oPeak), 64'd2000);

        // Frame 1: no samples, 2000 holds throughout, 0 at its end
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 0);
        chk("peak_f1", 64'(if3.oPeak), 64'd0);

        // Frame 2: saturation
        for (int i = 0; i < FRAME; i++) cycle(i == 10, -32768);
        chk("peak_sat", 64'(if1.oPeak), 64'd32767);

        // Frame 3: sample only in the frame-end cycle
        for (int i = 0; i < FRAME; i++) cycle(i == FRAME - 1, 700);
        chk("peak_edge", 64'(if1.oPeak), 64'd700);

        // Frame 4: next run started at 0
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 0);
        chk("peak_next", 64'(if1.oPeak), 64'd0);

        // Frame 5: all colour inputs zero (border only when enabled)
        zero_col = 1'b1;
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 0);
        zero_col = 1'b0;

        // Mid-frame reset at hcnt=5, vcnt=2 with run=900
        for (int i = 0; i < 2 * HT + 5; i++) cycle(i == 10, 900);
        chk("pre_rst_h", 64'(mh), 64'd5);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst1");
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst2");
        rst_n = 1'b1;
        init_model();
        chk("rel2_oX", 64'(if1.oX), 64'd0);
        chk("rel2_oY", 64'(if1.oY), 64'd0);
        chk("rel2_oFS", 64'(if3.oFS), 64'd0);

        // The discarded run must not reappear
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 0);
        chk("peak_after_rst", 64'(if1.oPeak), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
